// File: rtl/spi_bus_arbiter.sv
// Round-robin owner of the shared SPI bus: chip-select sequencing, mode-3 SCLK
// generation and shift/sample strobes for the three requester datapaths.
//
//   state | meaning
//   IDLE  | bus free, arbitrating among req_i
//   SETUP | cs asserted, sclk high, waiting CS_SETUP cycles
//   XFER  | sclk toggling, one bit per 2*CLK_DIV cycles
//   HOLD  | sclk high, cs still asserted for CS_HOLD cycles
//   GAP   | cs released, done pulse to the owner
module spi_bus_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int LEN_W    = 13,
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_REQ-1:0]       req_i,
    input  logic [NUM_REQ*LEN_W-1:0] len_i,
    input  logic                     abort_i,
    output logic [NUM_REQ-1:0]       grant_o,
    output logic [NUM_REQ-1:0]       cs_o,
    output logic                     sclk_o,
    output logic                     shift_stb_o,
    output logic                     sample_stb_o,
    output logic [LEN_W-1:0]         bit_cnt_o,
    output logic                     busy_o,
    output logic [NUM_REQ-1:0]       done_o,
    output logic                     aborted_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TMR_W = 16;
    localparam logic [TMR_W-1:0] SETUP_LD = TMR_W'(CS_SETUP - 1);
    localparam logic [TMR_W-1:0] HOLD_LD  = TMR_W'(CS_HOLD - 1);
    localparam logic [TMR_W-1:0] DIV_LD   = TMR_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_XFER,
        S_HOLD,
        S_GAP
    } state_t;

    state_t              r_state;
    logic [PTR_W-1:0]    r_ptr;
    logic [NUM_REQ-1:0]  r_grant;
    logic                r_sclk;
    logic                r_shift;
    logic                r_sample;
    logic [LEN_W-1:0]    r_bit_cnt;
    logic                r_busy;
    logic [NUM_REQ-1:0]  r_done;
    logic                r_aborted;
    logic [TMR_W-1:0]    r_tmr;
    logic                r_abort_seen;

    logic [NUM_REQ-1:0]  w_rot;
    logic [PTR_W-1:0]    w_off;
    logic [PTR_W-1:0]    w_win;
    logic [PTR_W-1:0]    w_ptr_nxt;
    logic [NUM_REQ-1:0]  w_win_oh;
    logic [LEN_W-1:0]    w_win_len;
    logic                w_any;
    logic                w_tmr_tc;
    logic                w_abort;
    int                  w_sum;

    // Requests rotated so bit 0 is the requester the pointer favours.
    always_comb begin
        w_rot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (k == ((int'(r_ptr) + i) % NUM_REQ)) begin
                    w_rot[i] = req_i[k];
                end
            end
        end
        w_off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = PTR_W'(i);
            end
        end
        w_sum = int'(r_ptr) + int'(w_off);
        if (w_sum >= NUM_REQ) begin
            w_sum = w_sum - NUM_REQ;
        end
        w_win     = PTR_W'(w_sum);
        w_ptr_nxt = (w_win == PTR_W'(NUM_REQ - 1)) ? '0 : w_win + PTR_W'(1);
        w_win_oh  = '0;
        w_win_len = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_win == PTR_W'(k)) begin
                w_win_oh[k] = 1'b1;
                w_win_len   = len_i[k*LEN_W +: LEN_W];
            end
        end
    end

    assign w_any    = |req_i;
    assign w_tmr_tc = (r_tmr == '0);
    assign w_abort  = abort_i | r_abort_seen;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_ptr        <= '0;
            r_grant      <= '0;
            r_sclk       <= 1'b1;
            r_shift      <= 1'b0;
            r_sample     <= 1'b0;
            r_bit_cnt    <= '0;
            r_busy       <= 1'b0;
            r_done       <= '0;
            r_aborted    <= 1'b0;
            r_tmr        <= '0;
            r_abort_seen <= 1'b0;
        end else begin
            r_shift   <= 1'b0;
            r_sample  <= 1'b0;
            r_done    <= '0;
            r_aborted <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant      <= w_win_oh;
                        r_bit_cnt    <= w_win_len;
                        r_ptr        <= w_ptr_nxt;
                        r_tmr        <= SETUP_LD;
                        r_abort_seen <= 1'b0;
                        r_busy       <= 1'b1;
                        r_state      <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (abort_i) begin
                        r_abort_seen <= 1'b1;
                        r_tmr        <= HOLD_LD;
                        r_state      <= S_HOLD;
                    end else if (w_tmr_tc) begin
                        if (r_bit_cnt == '0) begin
                            r_tmr   <= HOLD_LD;
                            r_state <= S_HOLD;
                        end else begin
                            r_sclk  <= 1'b0;
                            r_shift <= 1'b1;
                            r_tmr   <= DIV_LD;
                            r_state <= S_XFER;
                        end
                    end else begin
                        r_tmr <= r_tmr - TMR_W'(1);
                    end
                end
                S_XFER: begin
                    if (abort_i) begin
                        r_abort_seen <= 1'b1;
                    end
                    if (!r_sclk) begin
                        // A low phase always runs to completion; an abort only suppresses the sample.
                        if (w_tmr_tc) begin
                            r_sclk <= 1'b1;
                            if (w_abort) begin
                                r_tmr   <= HOLD_LD;
                                r_state <= S_HOLD;
                            end else begin
                                r_sample  <= 1'b1;
                                r_bit_cnt <= r_bit_cnt - LEN_W'(1);
                                r_tmr     <= DIV_LD;
                            end
                        end else begin
                            r_tmr <= r_tmr - TMR_W'(1);
                        end
                    end else if (w_abort) begin
                        r_tmr   <= HOLD_LD;
                        r_state <= S_HOLD;
                    end else if (w_tmr_tc) begin
                        if (r_bit_cnt == '0) begin
                            r_tmr   <= HOLD_LD;
                            r_state <= S_HOLD;
                        end else begin
                            r_sclk  <= 1'b0;
                            r_shift <= 1'b1;
                            r_tmr   <= DIV_LD;
                        end
                    end else begin
                        r_tmr <= r_tmr - TMR_W'(1);
                    end
                end
                S_HOLD: begin
                    if (w_tmr_tc) begin
                        r_grant   <= '0;
                        r_done    <= r_grant;
                        r_aborted <= r_abort_seen;
                        r_state   <= S_GAP;
                    end else begin
                        r_tmr <= r_tmr - TMR_W'(1);
                    end
                end
                S_GAP: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign grant_o      = r_grant;
    assign cs_o         = r_grant;
    assign sclk_o       = r_sclk;
    assign shift_stb_o  = r_shift;
    assign sample_stb_o = r_sample;
    assign bit_cnt_o    = r_bit_cnt;
    assign busy_o       = r_busy;
    assign done_o       = r_done;
    assign aborted_o    = r_aborted;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter: arbitration order, cs/sclk timing,
// zero-length, abort, async reset and latched-request behaviour.
`timescale 1ns/1ps
module tb_spi_bus_arbiter;

    localparam int NUM_REQ  = 3;
    localparam int LEN_W    = 13;
    localparam int CLK_DIV  = 2;
    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;

    logic                     clk_i = 1'b0;
    logic                     rst_i;
    logic [NUM_REQ-1:0]       req_i;
    logic [NUM_REQ*LEN_W-1:0] len_i;
    logic                     abort_i;
    logic [NUM_REQ-1:0]       grant_o;
    logic [NUM_REQ-1:0]       cs_o;
    logic                     sclk_o;
    logic                     shift_stb_o;
    logic                     sample_stb_o;
    logic [LEN_W-1:0]         bit_cnt_o;
    logic                     busy_o;
    logic [NUM_REQ-1:0]       done_o;
    logic                     aborted_o;

    spi_bus_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .LEN_W    (LEN_W),
        .CLK_DIV  (CLK_DIV),
        .CS_SETUP (CS_SETUP),
        .CS_HOLD  (CS_HOLD)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_i        (req_i),
        .len_i        (len_i),
        .abort_i      (abort_i),
        .grant_o      (grant_o),
        .cs_o         (cs_o),
        .sclk_o       (sclk_o),
        .shift_stb_o  (shift_stb_o),
        .sample_stb_o (sample_stb_o),
        .bit_cnt_o    (bit_cnt_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .aborted_o    (aborted_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Bus monitor, sampled on the falling edge.
    int         cs_hi [3] = '{0, 0, 0};
    int         n_shift   = 0;
    int         n_sample  = 0;
    int         n_edge    = 0;
    int         n_done    = 0;
    int         viol      = 0;
    int         low_run   = 0;
    int         gap_run   = 0;
    bit         seen_grant = 1'b0;
    logic       prev_sclk = 1'b1;
    logic [2:0] prev_cs   = '0;
    int         grant_q [$];
    int         gaps_q  [$];

    initial forever begin
        @(negedge clk_i);
        if (rst_i) begin
            prev_sclk  = 1'b1;
            prev_cs    = '0;
            low_run    = 0;
            gap_run    = 0;
            seen_grant = 1'b0;
        end else begin
            for (int k = 0; k < 3; k++) if (cs_o[k]) cs_hi[k]++;
            if (cs_o !== grant_o) viol++;
            if ((cs_o & (cs_o - 3'd1)) != 3'd0) viol++;
            if (prev_cs != 3'd0 && cs_o != 3'd0 && cs_o != prev_cs) viol++;
            if (shift_stb_o !== (prev_sclk & ~sclk_o)) viol++;
            if (sample_stb_o && !(~prev_sclk & sclk_o)) viol++;
            if (!sclk_o && cs_o == 3'd0) viol++;
            if (sclk_o != prev_sclk) n_edge++;
            if (!sclk_o) low_run++;
            else begin
                if (!prev_sclk && low_run != CLK_DIV) viol++;
                low_run = 0;
            end
            if (shift_stb_o) n_shift++;
            if (sample_stb_o) n_sample++;
            if (done_o != 3'd0) begin
                n_done++;
                if (done_o !== prev_cs || cs_o != 3'd0) viol++;
            end
            if (aborted_o && done_o == 3'd0) viol++;
            if (prev_cs == 3'd0 && cs_o != 3'd0) begin
                grant_q.push_back(cs_o[0] ? 0 : (cs_o[1] ? 1 : 2));
                if (seen_grant) gaps_q.push_back(gap_run);
                seen_grant = 1'b1;
                gap_run    = 0;
            end
            if (cs_o == 3'd0) gap_run++;
            prev_cs   = cs_o;
            prev_sclk = sclk_o;
        end
    end

    task automatic tick();
        @(negedge clk_i);
        #1;
    endtask

    task automatic set_len(input int k, input int val);
        len_i[k*LEN_W +: LEN_W] = LEN_W'(val);
    endtask

    task automatic wait_done(input int max_cyc, output logic [2:0] d, output logic ab);
        bit found;
        found = 1'b0;
        d  = '0;
        ab = 1'b0;
        for (int i = 0; i < max_cyc && !found; i++) begin
            tick();
            if (done_o != 3'd0) begin
                d     = done_o;
                ab    = aborted_o;
                found = 1'b1;
            end
        end
        if (!found) check_val("done_timeout", 0, 1);
    endtask

    task automatic do_xfer(input string tag, input logic [2:0] req, input logic [2:0] exp_g);
        logic [2:0] d;
        logic       ab;
        req_i = req;
        tick();
        check_val({tag, "_grant"}, grant_o, exp_g);
        req_i = '0;
        wait_done(2000, d, ab);
        check_val({tag, "_done"}, d, exp_g);
        tick();
        tick();
    endtask

    initial begin
        logic [2:0] d;
        logic       ab;
        int b_cs0, b_cs1, b_cs2, b_sh, b_sa, b_ed, b_dn, gb, pb;

        rst_i   = 1'b1;
        req_i   = '0;
        len_i   = '0;
        abort_i = 1'b0;
        tick();
        tick();
        check_val("rst_cs_grant", {cs_o, grant_o}, 0);
        check_val("rst_sclk", sclk_o, 1);
        check_val("rst_flags", {shift_stb_o, sample_stb_o, busy_o, done_o, aborted_o}, 0);
        check_val("rst_bitcnt", bit_cnt_o, 0);
        rst_i = 1'b0;
        tick();
        tick();

        // 1: single 8-bit transfer: cs high 2 + 2*2*8 + 2 = 36 cycles
        set_len(0, 8);
        b_cs0 = cs_hi[0]; b_sh = n_shift; b_sa = n_sample; b_ed = n_edge;
        req_i = 3'b001;
        tick();
        check_val("t1_grant", grant_o, 3'b001);
        check_val("t1_bitcnt_load", bit_cnt_o, 8);
        check_val("t1_busy", busy_o, 1);
        req_i = '0;
        wait_done(200, d, ab);
        check_val("t1_done", d, 3'b001);
        check_val("t1_aborted", ab, 0);
        check_val("t1_gap_busy_cs", {busy_o, cs_o}, 4'b1000);
        tick();
        check_val("t1_after_done", {done_o, busy_o}, 0);
        check_val("t1_cs_len", cs_hi[0] - b_cs0, 36);
        check_val("t1_shifts", n_shift - b_sh, 8);
        check_val("t1_samples", n_sample - b_sa, 8);
        check_val("t1_edges", n_edge - b_ed, 16);
        check_val("t1_bitcnt_end", bit_cnt_o, 0);
        tick();

        // 2: all three requesting, pointer restarted at 0
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) set_len(k, 4);
        b_cs0 = cs_hi[0]; b_cs1 = cs_hi[1]; b_cs2 = cs_hi[2]; b_dn = n_done;
        gb = grant_q.size(); pb = gaps_q.size();
        req_i = 3'b111;
        for (int i = 0; i < 400 && (grant_q.size() - gb) < 4; i++) tick();
        req_i = '0;
        for (int i = 0; i < 200 && (n_done - b_dn) < 4; i++) tick();
        tick(); tick(); tick();
        check_val("t2_grant_cnt", grant_q.size() - gb, 4);
        check_val("t2_order", {grant_q[gb][1:0], grant_q[gb+1][1:0], grant_q[gb+2][1:0], grant_q[gb+3][1:0]}, 8'b00_01_10_00);
        check_val("t2_gap_cnt", gaps_q.size() - pb, 3);
        // cs-low gap between back-to-back owners: GAP cycle plus one IDLE arbitration cycle
        check_val("t2_gaps", {gaps_q[pb][3:0], gaps_q[pb+1][3:0], gaps_q[pb+2][3:0]}, {4'd2, 4'd2, 4'd2});
        check_val("t2_cs_lens", {cs_hi[0] - b_cs0, cs_hi[1] - b_cs1, cs_hi[2] - b_cs2}, {32'd40, 32'd20, 32'd20});
        check_val("t2_dones", n_done - b_dn, 4);
        check_val("t2_invariants", viol, 0);

        // 3: zero-length transfer on requester 1
        set_len(1, 0);
        b_cs1 = cs_hi[1]; b_sh = n_shift; b_sa = n_sample; b_ed = n_edge;
        do_xfer("t3", 3'b010, 3'b010);
        check_val("t3_cs_len", cs_hi[1] - b_cs1, 4);
        check_val("t3_no_sclk", {n_edge - b_ed, n_shift - b_sh, n_sample - b_sa}, 0);

        // 4: abort in the high phase right after the 5th sample
        set_len(0, 16);
        b_cs0 = cs_hi[0]; b_sh = n_shift; b_sa = n_sample; b_ed = n_edge;
        req_i = 3'b001;
        tick();
        check_val("t4_grant", grant_o, 3'b001);
        req_i = '0;
        for (int i = 0; i < 300 && (n_sample - b_sa) < 5; i++) tick();
        check_val("t4_reach5", n_sample - b_sa, 5);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        wait_done(200, d, ab);
        check_val("t4_done", d, 3'b001);
        check_val("t4_aborted", ab, 1);
        check_val("t4_bitcnt", bit_cnt_o, 11);
        check_val("t4_sclk", sclk_o, 1);
        check_val("t4_samples", n_sample - b_sa, 5);
        check_val("t4_shifts", n_shift - b_sh, 5);
        check_val("t4_edges", n_edge - b_ed, 10);
        check_val("t4_cs_len", cs_hi[0] - b_cs0, 23);
        tick(); tick();

        // 4b: abort in a low phase: sclk still rises after CLK_DIV, without a sample
        set_len(1, 16);
        b_cs1 = cs_hi[1]; b_sh = n_shift; b_sa = n_sample; b_ed = n_edge;
        req_i = 3'b010;
        tick();
        check_val("t4b_grant", grant_o, 3'b010);
        req_i = '0;
        for (int i = 0; i < 300 && (n_shift - b_sh) < 3; i++) tick();
        check_val("t4b_low", sclk_o, 0);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        wait_done(200, d, ab);
        check_val("t4b_done", {d, ab}, 4'b0101);
        check_val("t4b_bitcnt", bit_cnt_o, 14);
        check_val("t4b_counts", {n_shift - b_sh, n_sample - b_sa, n_edge - b_ed}, {32'd3, 32'd2, 32'd6});
        check_val("t4b_cs_len", cs_hi[1] - b_cs1, 14);
        tick(); tick();

        // 5: asynchronous reset in a low phase of XFER
        set_len(0, 8);
        b_sh = n_shift; b_dn = n_done;
        req_i = 3'b001;
        tick();
        check_val("t5_grant", grant_o, 3'b001);
        req_i = '0;
        for (int i = 0; i < 200 && (n_shift - b_sh) < 2; i++) tick();
        check_val("t5_pre_sclk", sclk_o, 0);
        #2 rst_i = 1'b1;
        #1;
        check_val("t5_rst_cs", {cs_o, grant_o}, 0);
        check_val("t5_rst_sclk", sclk_o, 1);
        check_val("t5_rst_busy_cnt", {busy_o, bit_cnt_o}, 0);
        tick();
        rst_i = 1'b0;
        tick(); tick(); tick();
        check_val("t5_no_done", n_done - b_dn, 0);
        for (int k = 0; k < 3; k++) set_len(k, 4);
        do_xfer("t5_ptr0", 3'b011, 3'b001);
        do_xfer("t5_req2", 3'b100, 3'b100);

        // 6: req dropped and len changed mid-transfer
        set_len(0, 8);
        b_cs0 = cs_hi[0]; b_sa = n_sample; gb = grant_q.size();
        req_i = 3'b001;
        tick();
        check_val("t6_grant", grant_o, 3'b001);
        for (int i = 0; i < 200 && (n_sample - b_sa) < 2; i++) tick();
        req_i = '0;
        set_len(0, 3);
        wait_done(200, d, ab);
        check_val("t6_done", {d, ab}, 4'b0010);
        check_val("t6_samples", n_sample - b_sa, 8);
        check_val("t6_cs_len", cs_hi[0] - b_cs0, 36);
        tick(); tick(); tick(); tick();
        check_val("t6_no_regrant", {grant_o, busy_o}, 0);
        check_val("t6_grant_cnt", grant_q.size() - gb, 1);
        check_val("invariants", viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
